// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration chain master.
package cfg_pkg;

    localparam int unsigned WORD_W_DEF  = 16;
    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned CLK_DIV_MIN = 4;
    localparam int unsigned CLK_DIV_MAX = 255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/config_if.sv
// Serial configuration link: a data clock plus one data bit.
interface config_if;
    logic data_clk;
    logic data_in;

    modport master (output data_clk, output data_in);
    modport slave  (input  data_clk, input  data_in);
endinterface

// File: rtl/cfg_clk_gen.sv
// Chain clock generator: data_clk toggles every CLK_DIV clk cycles while run is high.
module cfg_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic data_clk,
    output logic phase_end_lo_c,
    output logic phase_end_hi_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             last_c;

    assign last_c         = (cnt == CNT_W'(CLK_DIV - 1));
    assign phase_end_lo_c = run && !data_clk && last_c;
    assign phase_end_hi_c = run &&  data_clk && last_c;

    // Stopping the generator parks data_clk low with the phase counter cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            data_clk <= 1'b0;
        end else if (!run) begin
            cnt      <= '0;
            data_clk <= 1'b0;
        end else if (last_c) begin
            cnt      <= '0;
            data_clk <= ~data_clk;
        end else begin
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/config_chain_master.sv
// Shifts parallel config words MSB-first into the config daisy chain and
// collects the bits falling out of the chain tail as readback words.
module config_chain_master
    import cfg_pkg::*;
#(
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              wr_last,
    output logic              wr_ready,
    config_if.master          cfg_out,
    config_if.slave           cfg_ret,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_CNT_W = $clog2(WORD_W);

    generate
        if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
            $error("config_chain_master: CLK_DIV outside legal range");
        end
        if (WORD_W < 2) begin : g_bad_word_w
            $error("config_chain_master: WORD_W must be at least 2");
        end
    endgenerate

    cfg_state_t           state, state_d;
    logic [WORD_W-1:0]    shreg;
    logic [WORD_W-1:0]    rd_shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 last_q;
    logic                 tail_meta, tail_sync;
    logic                 data_clk_q;
    logic                 run_c, accept_c, load_c, step_c, finish_c, sample_c;
    logic                 phase_end_lo_c, phase_end_hi_c;

    assign run_c          = (state == SHIFT_LO) || (state == SHIFT_HI);
    assign sample_c       = (state == SHIFT_LO) && phase_end_lo_c;
    assign cfg_out.data_clk = data_clk_q;
    assign cfg_out.data_in  = shreg[WORD_W-1];

    cfg_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk            (clk),
        .reset          (reset),
        .run            (run_c),
        .data_clk       (data_clk_q),
        .phase_end_lo_c (phase_end_lo_c),
        .phase_end_hi_c (phase_end_hi_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and one-cycle datapath controls
    always_comb begin
        state_d  = state;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        accept_c = wr_valid && wr_ready;
        case (state)
            IDLE, GAP: begin
                if (accept_c) begin
                    state_d = SHIFT_LO;
                    load_c  = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_end_lo_c) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end_hi_c) begin
                    if (bit_cnt != '0) begin
                        state_d = SHIFT_LO;
                        step_c  = 1'b1;
                    end else begin
                        state_d  = last_q ? DONE : GAP;
                        finish_c = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tail bit crosses into clk through two flops; it is stable long before sampling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_meta <= 1'b0;
            tail_sync <= 1'b0;
        end else begin
            tail_meta <= cfg_ret.data_in;
            tail_sync <= tail_meta;
        end
    end

    // data_in is the shift register MSB, so it only moves on load or a falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            rd_shreg <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= finish_c;
            done     <= (state == DONE);
            wr_ready <= (state_d == IDLE) || (state_d == GAP);
            busy     <= (state_d == SHIFT_LO) || (state_d == SHIFT_HI) ||
                        (state_d == GAP)      || (state_d == DONE);
            if (load_c) begin
                shreg   <= wr_data;
                bit_cnt <= BIT_CNT_W'(WORD_W - 1);
                last_q  <= wr_last;
            end
            if (step_c) begin
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            end
            if (sample_c) begin
                rd_shreg <= {rd_shreg[WORD_W-2:0], tail_sync};
            end
            if (finish_c) begin
                rd_data <= rd_shreg;
            end
        end
    end

endmodule

// File: tb/tb_config_chain_master.sv
// Directed bench for config_chain_master with a chain model and readback scoreboard.
module tb_config_chain_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] wr_data;
    logic        wr_valid, wr_last, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, busy, done;

    config_if cfg_out_if ();
    config_if cfg_ret_if ();

    config_chain_master #(.WORD_W(16), .CLK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .cfg_out  (cfg_out_if),
        .cfg_ret  (cfg_ret_if),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done)
    );

    // Second instance at CLK_DIV=5 with the tail looped straight back to the head
    logic [15:0] wr5_data;
    logic        wr5_valid, wr5_last, wr5_ready;
    logic [15:0] rd5_data;
    logic        rd5_valid, busy5, done5;

    config_if cfg5_out_if ();
    config_if cfg5_ret_if ();
    assign cfg5_ret_if.data_clk = cfg5_out_if.data_clk;
    assign cfg5_ret_if.data_in  = cfg5_out_if.data_in;

    config_chain_master #(.WORD_W(16), .CLK_DIV(5)) dut5 (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr5_data),
        .wr_valid (wr5_valid),
        .wr_last  (wr5_last),
        .wr_ready (wr5_ready),
        .cfg_out  (cfg5_out_if),
        .cfg_ret  (cfg5_ret_if),
        .rd_data  (rd5_data),
        .rd_valid (rd5_valid),
        .busy     (busy5),
        .done     (done5)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chain model: shifts on the rising data_clk, tail is bit tail_idx
    logic [31:0] chain;
    logic [31:0] preload_val;
    logic        preload = 1'b0;
    logic [4:0]  tail_idx = 5'd15;

    assign cfg_ret_if.data_clk = cfg_out_if.data_clk;
    assign cfg_ret_if.data_in  = chain[tail_idx];

    always @(posedge cfg_ret_if.data_clk or posedge preload) begin
        if (preload) chain <= preload_val;
        else         chain <= {chain[30:0], cfg_out_if.data_in};
    end

    logic bits_q[$];
    int   rise_cnt = 0;
    always @(posedge cfg_out_if.data_clk) begin
        bits_q.push_back(cfg_out_if.data_in);
        rise_cnt++;
    end

    // Monitors and scoreboard
    logic [15:0] exp_q[$];
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, rd_cnt = 0, rd_cyc = 0;
    int done_cnt = 0, done_cyc = 0, lo_run = 0, lo_max = 0;

    always @(posedge clk) begin
        cyc++;
        if (wr_valid && wr_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (rd_valid) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
            else                   chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !cfg_out_if.data_clk) begin
            lo_run++;
        end else begin
            if (lo_run > lo_max) lo_max = lo_run;
            lo_run = 0;
        end
    end

    logic        dc5_prev = 1'b0, din5_prev = 1'b0, dc5_seen = 1'b0;
    int          dc5_edge = 0, din5_edge = -100, rise5_cyc = -100;
    int          ph_n = 0, ph_bad = 0, su_bad = 0, done5_cnt = 0;
    logic [15:0] rd5_val = 16'h0;

    always @(negedge clk) begin
        if (cfg5_out_if.data_clk !== dc5_prev) begin
            if (dc5_seen) begin
                ph_n++;
                if (cyc - dc5_edge != 5) ph_bad++;
            end
            dc5_seen = 1'b1;
            dc5_edge = cyc;
            if (cfg5_out_if.data_clk === 1'b1) begin
                if (cyc - din5_edge < 4) su_bad++;
                rise5_cyc = cyc;
            end
            dc5_prev = cfg5_out_if.data_clk;
        end
        if (cfg5_out_if.data_in !== din5_prev) begin
            if (cyc - rise5_cyc < 4) su_bad++;
            din5_edge = cyc;
            din5_prev = cfg5_out_if.data_in;
        end
        if (rd5_valid) rd5_val = rd5_data;
        if (done5)     done5_cnt++;
    end

    // Reference contents of the chain, advanced as words are driven
    logic [31:0] model;
    int unsigned model_len;

    task automatic load_chain(input logic [31:0] v, input int unsigned len);
        preload_val = v;
        tail_idx    = 5'(len - 1);
        model       = v;
        model_len   = len;
        preload     = 1'b1;
        #1 preload  = 1'b0;
    endtask

    task automatic drive(input logic [15:0] w, input logic last);
        logic [31:0] mask;
        mask = (model_len == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        exp_q.push_back(16'(model >> (model_len - 16)));
        model    = ((model << 16) | 32'(w)) & mask;
        wr_data  = w;
        wr_last  = last;
        wr_valid = 1'b1;
    endtask

    task automatic wait_acc(input string tag);
        int n0, t;
        n0 = acc_cnt;
        t  = 0;
        while (acc_cnt == n0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_accepted"}, 32'(acc_cnt - n0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n0, t;
        n0 = done_cnt;
        t  = 0;
        while (done_cnt == n0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt - n0), 32'd1);
    endtask

    logic [15:0] seq;
    int          n0, t;

    initial begin
        reset     = 1'b1;
        wr_data   = '0; wr_valid  = 1'b0; wr_last  = 1'b0;
        wr5_data  = '0; wr5_valid = 1'b0; wr5_last = 1'b0;
        #2 reset = 1'b0;
        load_chain(32'h0000_1234, 16);
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({wr_ready, busy, done, rd_valid, cfg_out_if.data_clk,
                               cfg_out_if.data_in, rd_data}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", 32'(wr_ready), 32'd1);

        // Single word into a 16-bit chain
        bits_q.delete();
        drive(16'hA5C3, 1'b1);
        wait_acc("t1");
        wr_valid = 1'b0;
        wait_done("t1");
        chk("t1_latency", 32'(rd_cyc - acc_cyc), 32'd128);
        chk("t1_done_lat", 32'(done_cyc - rd_cyc), 32'd1);
        seq = '0;
        for (int i = 0; i < bits_q.size(); i++) seq = {seq[14:0], bits_q[i]};
        chk("t1_nbits", 32'(bits_q.size()), 32'd16);
        chk("t1_seq", 32'(seq), 32'h0000_A5C3);
        chk("t1_chain", 32'(chain[15:0]), 32'h0000_A5C3);

        // Back-to-back two-word frame on a 32-bit chain
        load_chain(32'hDEAD_BEEF, 32);
        lo_max = 0;
        drive(16'h1357, 1'b0);
        wait_acc("t2a");
        drive(16'h2468, 1'b1);
        wait_acc("t2b");
        wr_valid = 1'b0;
        wait_done("t2");
        chk("t2_low_max", 32'(lo_max), 32'd5);
        chk("t2_chain", chain, 32'h1357_2468);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Same frame with a long gap between the words
        load_chain(32'hDEAD_BEEF, 32);
        drive(16'h1357, 1'b0);
        wait_acc("t3a");
        wr_valid = 1'b0;
        n0 = rd_cnt; t = 0;
        while (rd_cnt == n0 && t < 2000) begin @(negedge clk); t++; end
        repeat (25) @(negedge clk);
        chk("gap_data_clk", 32'(cfg_out_if.data_clk), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        repeat (25) @(negedge clk);
        drive(16'h2468, 1'b1);
        wait_acc("t3b");
        wr_valid = 1'b0;
        wait_done("t3");
        chk("t3_chain", chain, 32'h1357_2468);

        // Second word offered during SHIFT_HI must wait for the gap
        load_chain(32'h0F0F_F0F0, 32);
        n0 = acc_cnt;
        drive(16'hC001, 1'b0);
        wait_acc("t4a");
        wr_valid = 1'b0;
        t = 0;
        while (cfg_out_if.data_clk !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        drive(16'h0BAD, 1'b1);
        chk("bp_ready_low", 32'(wr_ready), 32'd0);
        wait_acc("t4b");
        chk("bp_accept_after_rd", 32'(acc_cyc - rd_cyc), 32'd1);
        wr_valid = 1'b0;
        wait_done("t4");
        chk("bp_accept_count", 32'(acc_cnt - n0), 32'd2);
        chk("t4_chain", chain, 32'hC001_0BAD);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while bit 7 is being clocked
        load_chain(32'h0000_5A5A, 16);
        drive(16'h1111, 1'b1);
        wait_acc("t5a");
        wr_valid = 1'b0;
        n0 = rise_cnt; t = 0;
        while (rise_cnt - n0 < 8 && t < 2000) begin @(negedge clk); t++; end
        chk("rst_pre_clk", 32'(cfg_out_if.data_clk), 32'd1);
        #2 reset = 1'b0;
        #1 chk("rst_outs", 32'({cfg_out_if.data_clk, busy, rd_valid, done}), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        load_chain(32'h0000_3C3C, 16);
        drive(16'hFFFF, 1'b1);
        wait_acc("t5b");
        wr_valid = 1'b0;
        wait_done("t5");
        chk("t5_chain", 32'(chain[15:0]), 32'h0000_FFFF);

        // Duty cycle and data_in stability at CLK_DIV=5
        wr5_data  = 16'h9A6D;
        wr5_last  = 1'b1;
        wr5_valid = 1'b1;
        t = 0;
        while (wr5_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        wr5_valid = 1'b0;
        t = 0;
        while (done5_cnt == 0 && t < 1000) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        chk("d5_done", 32'(done5_cnt), 32'd1);
        chk("d5_phases", 32'(ph_n), 32'd31);
        chk("d5_phase_len_bad", 32'(ph_bad), 32'd0);
        chk("d5_setup_hold_bad", 32'(su_bad), 32'd0);
        chk("d5_loopback_rd", 32'(rd5_val), 32'h0000_9A6D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/config_chain_master.md
Name: config_chain_master

Overview:
- Parallel-to-serial driver for the configuration daisy chain.
- Accepts parallel config words over a valid/ready port and shifts them MSB-first onto the master side of a config_if.
- Generates the chain's data_clk from the system clock.
- Captures the bits falling out of the chain tail into readback words, so software can verify the chain and read its old contents.
- Sits between the config register file and the first dendrite/synapse in the chain.

Parameters:
- WORD_W, 16, bits per config word and per readback word.
- CLK_DIV, 4, clk cycles per data_clk half-period; legal range 4..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- wr_data  input  WORD_W  config word to shift.
- wr_valid  input  1  wr_data valid.
- wr_last  input  1  word is the final word of the frame; qualified by wr_valid.
- wr_ready  output  1  word accepted when wr_valid and wr_ready are both high.
- cfg_out  config_if.master  -  drives data_clk and data_in into the chain head.
- cfg_ret  config_if.slave  -  data_in from the chain tail.
- rd_data  output  WORD_W  readback word.
- rd_valid  output  1  one-cycle strobe; rd_data is valid in that cycle.
- busy  output  1  high from word accept until the frame completes.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0, data_clk 0, data_in 0, FSM in IDLE, any partial frame discarded.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, GAP, DONE.
- IDLE: wr_ready=1. On accept:
  - latch the word into the shift register and set bit_cnt=WORD_W-1.
  - capture wr_last.
  - drive data_in=word[WORD_W-1].
  - go to SHIFT_LO with busy=1.
- SHIFT_LO: data_clk=0 for CLK_DIV cycles.
  - On the final cycle, sample the synchronized tail bit into the readback register, LSB-in.
  - Then go to SHIFT_HI.
- SHIFT_HI: data_clk=1 for CLK_DIV cycles. On the final cycle:
  - If bit_cnt>0: decrement bit_cnt, present the next bit on data_in, go to SHIFT_LO. data_in changes only at the falling edge, giving CLK_DIV cycles of setup and hold around each rising edge.
  - If bit_cnt==0: pulse rd_valid with the completed readback word; go to DONE if last, otherwise GAP.
- GAP: data_clk=0, wr_ready=1. Holding here is indefinite; the chain is static, so gaps are legal. On accept, load the word and go to SHIFT_LO as in IDLE.
- DONE: done=1 for exactly 1 cycle, busy=0, then go to IDLE.
- Tail input cfg_ret.data_in passes through a 2-flop synchronizer into the clk domain. CLK_DIV>=4 guarantees the value is settled before sampling.
- wr_ready is 0 in SHIFT_LO, SHIFT_HI and DONE. wr_valid seen in those states waits; no word is dropped or duplicated.
- data_clk is a register output, glitch-free, with 50% duty. Period is 2*CLK_DIV clk cycles.
- Frame timing: one word takes WORD_W*2*CLK_DIV cycles from accept to rd_valid. rd_valid asserts in the same cycle as the last data_clk falling edge.
- Readback alignment: bit k of the frame's serial stream emerges as the tail bit sampled before rising edge k. A chain of N bits therefore returns its old contents in the first N bits.
- Simultaneous events:
  - wr_valid with wr_last during GAP: the word is accepted and the frame ends after it.
  - reset asserted mid-shift: data_clk drops to 0 immediately (asynchronous). The chain may hold a partially shifted word; software must reshift the full frame.

Decomposition:
- Shared package cfg_pkg holds:
  - the state enum cfg_state_t;
  - the WORD_W default constant;
  - a CLK_DIV_MIN=4 constant, with an elaboration-time check in the module.
- Sub-module cfg_clk_gen holds the phase counter and the data_clk register. It outputs phase_end_lo and phase_end_hi strobes and takes a run enable. The master FSM consumes those strobes only.

Test Plan:
- Single word, WORD_W=16, CLK_DIV=4, wr_data=16'hA5C3, wr_last=1, chain model 16 bits preloaded 16'h1234:
  - data_in follows the 1010 0101 1100 0011 bit sequence at 16 rising edges.
  - rd_valid with rd_data=16'h1234 at cycle 128 after accept.
  - done 1 cycle later; chain model then holds 16'hA5C3.
- Two-word frame on a 32-bit chain, wr_valid held high:
  - second word is accepted in GAP within 1 cycle, so data_clk shows no extended low.
  - two rd_valid strobes carry the old upper then lower word.
  - done occurs once only.
- Gap insertion: wr_valid low for 50 cycles between words -> data_clk stays 0, busy=1, and the final chain contents are identical to the back-to-back case.
- Backpressure: wr_valid asserted during SHIFT_HI -> wr_ready=0, and the word is accepted exactly once after rd_valid. A scoreboard confirms no loss and no duplicate.
- Reset mid-shift, at bit 7 of a word:
  - data_clk, busy, rd_valid and done are 0 in the same cycle.
  - after release, FSM is IDLE with wr_ready=1.
  - a fresh 16'hFFFF frame completes correctly.
- Duty check at CLK_DIV=5 -> every data_clk high and low phase is exactly 5 cycles, and data_in never changes within 4 cycles of a rising edge.
